// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the FIFO read port, the burst reader and the downstream stream.
// master = burst reader view, slave = FIFO/stream environment view.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_nempty;
  logic                  fifo_re;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;
  logic                  out_pad;

  modport master (
    input  fifo_nempty, fifo_data, out_ready,
    output fifo_re, out_valid, out_data, out_first, out_last, out_pad
  );

  modport slave (
    output fifo_nempty, fifo_data, out_ready,
    input  fifo_re, out_valid, out_data, out_first, out_last, out_pad
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops FIFO words into a 2-entry skid buffer and streams whole 2**BURST_LOG bursts, zero-padding on idle timeout or flush.
// Latency: word popped at edge N is valid in cycle N+1; backpressure: out_ready low with a full buffer stops pops.
module fifo_burst_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int BURST_LOG     = 3,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     rclk,
  input  logic                     rst_n,
  fifo_burst_reader_if.master      bus,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic                     flush,
  output logic                     busy,
  output logic [15:0]              burst_cnt
);

  typedef enum logic {RUN = 1'b0, PAD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mem_q [2];
  logic [DATA_WIDTH-1:0]    mem_d [2];
  logic [BURST_LOG-1:0]     word_idx_q, word_idx_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     flush_pend_q, flush_pend_d;
  logic [15:0]              burst_cnt_q, burst_cnt_d;

  logic in_pad;
  logic pop;
  logic out_valid;
  logic xfer;
  logic data_xfer;
  logic is_last;
  logic idle;
  logic timeout_hit;
  logic pad_enter;
  logic wr_slot1;

  assign in_pad      = (state_q == PAD);
  assign pop         = rst_n & ~in_pad & bus.fifo_nempty & (cnt_q != 2'd2);
  assign out_valid   = (cnt_q != 2'd0) | in_pad;
  assign xfer        = out_valid & bus.out_ready;
  assign data_xfer   = xfer & ~in_pad;
  assign is_last     = &word_idx_q;
  assign idle        = ~in_pad & (word_idx_q != '0) & (cnt_q == 2'd0) & ~bus.fifo_nempty;
  assign timeout_hit = (timeout != '0) & (timer_q == timeout);
  assign pad_enter   = idle & (flush_pend_q | timeout_hit);
  // A popped word lands behind the head unless the head leaves in the same cycle.
  assign wr_slot1    = (cnt_q == 2'd1) & ~data_xfer;

  assign bus.fifo_re   = pop;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = in_pad ? '0 : mem_q[0];
  assign bus.out_first = (word_idx_q == '0);
  assign bus.out_last  = is_last;
  assign bus.out_pad   = in_pad;

  assign busy      = (word_idx_q != '0) | (cnt_q != 2'd0) | in_pad;
  assign burst_cnt = burst_cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_d        = mem_q;
    word_idx_d   = word_idx_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    burst_cnt_d  = burst_cnt_q;

    if (data_xfer) begin
      mem_d[0] = mem_q[1];
    end
    if (pop) begin
      if (wr_slot1) begin
        mem_d[1] = bus.fifo_data;
      end else begin
        mem_d[0] = bus.fifo_data;
      end
    end
    cnt_d = cnt_q + {1'b0, pop} - {1'b0, data_xfer};

    if (xfer) begin
      word_idx_d = word_idx_q + BURST_LOG'(1);
      if (is_last) begin
        burst_cnt_d = burst_cnt_q + 16'd1;
      end
    end

    if (idle) begin
      if (timer_q != '1) begin
        timer_d = timer_q + TIMEOUT_WIDTH'(1);
      end
    end else begin
      timer_d = '0;
    end

    // Closing the burst (by padding or naturally) retires any request in the same cycle.
    if (pad_enter | (data_xfer & is_last)) begin
      flush_pend_d = 1'b0;
    end else if (flush & ~in_pad & ((word_idx_q != '0) | (cnt_q != 2'd0))) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      RUN: if (pad_enter) state_d = PAD;
      PAD: if (xfer & is_last) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= 2'd0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      word_idx_q   <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      burst_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      word_idx_q   <= word_idx_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule
